door_cmd_sched: RTL and testbench
=================================

# door_cmd_sched

Command scheduler in front of the door FSM (`fsm_door_1596`). It shares the FSM's `key_up`/`key_down` inputs between a local push-button panel and a remote command port, and supervises each motion with a travel timeout. It also recloses an opened door automatically after a hold time. It runs on the 2 MHz system clock, sits between the button/remote logic and the door FSM, and monitors the limit switches and motor outputs.

## Interface
- `DEBOUNCE_CYC`, default 20: consecutive high cycles before a local button press is accepted.
- `PULSE_CYC`, default 2: width of the key pulse to the door FSM, in cycles.
- `TRAVEL_TO_CYC`, default 4000: maximum cycles in MOVE before FAULT.
- `AUTOCLOSE_CYC`, default 20000: cycles in HOLD_OPEN before an automatic close.
- `clk2m` in 1: 2 MHz clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `loc_up`, `loc_down` in 1: raw local buttons, asynchronous.
- `rem_req` in 1: remote request, one-cycle pulse, synchronous to `clk2m`.
- `rem_dir` in 1: remote direction, valid with `rem_req`; 1 = up, 0 = down.
- `sense_up`, `sense_down` in 1: raw limit switches, asynchronous.
- `ml`, `mr` in 1: motor outputs of the door FSM, used for monitoring only.
- `fault_clr` in 1: one-cycle pulse that leaves FAULT.
- `key_up`, `key_down` out 1: key pulses to the door FSM.
- `grant_loc`, `grant_rem` out 1: owner of the current motion.
- `busy` out 1: high in ISSUE and MOVE.
- `fault` out 1: high in FAULT.
- `req_rej` out 1: one-cycle pulse on each rejected request.

## Operation
- Input conditioning:
  - `loc_*` and `sense_*` pass through 2-FF synchronizers.
  - Each `loc_*` then feeds a debounce counter. The debounced level rises after `DEBOUNCE_CYC` consecutive synced-high cycles and falls on the first synced-low cycle.
  - The rising edge of a debounced level gives a one-cycle event `ev_up` / `ev_down`.
- Request sources: local events, `rem_req`, and the internal auto-close.
- Arbitration, applied in the same cycle:
  - A local event beats a remote request. The losing request is rejected.
  - Local up and down together are both rejected.
- Acceptance:
  - Requests are accepted only in IDLE and HOLD_OPEN.
  - In ISSUE, MOVE or FAULT every request pulses `req_rej`. No request is queued.
  - An up request with synced `sense_up`=1 is rejected (already at end stop). The same applies to a down request with `sense_down`=1.
- States:
  - IDLE: keys 0, grants 0. An accepted request latches the direction and sets the grant for the winner, then goes to ISSUE.
  - ISSUE: assert `key_up` or `key_down` (per the latched direction) for exactly `PULSE_CYC` cycles, then go to MOVE. The travel counter clears.
  - MOVE:
    - Travel counter increments every cycle.
    - Target synced sensor = 1: up goes to HOLD_OPEN (auto-close counter clears), down goes to IDLE. Grants drop when the state is left.
    - `ml`&`mr` both 1 goes to FAULT immediately.
    - Counter reaching `TRAVEL_TO_CYC` without the target sensor goes to FAULT.
    - In MOVE, an in-range sensor check takes priority over the timeout in the same cycle.
  - HOLD_OPEN:
    - Auto-close counter increments.
    - Reaching `AUTOCLOSE_CYC` issues an internal down request (no grant set) and goes to ISSUE.
    - An accepted local or remote down request goes to ISSUE earlier.
    - Synced `sense_up` dropping goes to IDLE.
  - FAULT: keys 0, grants 0, `fault`=1. `fault_clr` goes to IDLE. `rst_n` also exits FAULT.
- Counters are sized to `$clog2(param+1)` bits and saturate; they never wrap.

## Timing
- Reset state is IDLE. Reset values: all outputs 0, counters 0, synchronizers 0, debounced levels 0.
- Reset is asynchronous: asserting `rst_n` mid-pulse drops `key_*` immediately, without waiting for the clock.
- All outputs are registered.
- Remote request latency: `rem_req` sampled high at edge E gives `key_*` high from edge E+1 to edge E+1+`PULSE_CYC`.
- Local request latency: raw press first sampled at edge E0 gives `key_*` high from edge E0+`DEBOUNCE_CYC`+3.
- Sensor latency: a sensor rising is acted on 2 edges later, because of the synchronizer.
- `req_rej` is asserted in the cycle after the rejected request.
- `busy` goes high on ISSUE entry and low on MOVE exit.

## Test plan
Parameters for all scenarios: `DEBOUNCE_CYC`=4, `PULSE_CYC`=2, `TRAVEL_TO_CYC`=16, `AUTOCLOSE_CYC`=8.

1. Remote up: `rem_req`=1 with `rem_dir`=1 at edge 10, `sense_down`=1 -> `key_up`=1 for edges 11–12, `grant_rem`=1, `busy`=1. `sense_up` rising at edge 20 -> HOLD_OPEN from edge 22. `key_down` pulses 8 cycles later; then `sense_down` -> IDLE, all outputs 0.
2. Debounce: `loc_down` high for 3 cycles, low, then high for 10 cycles, door open -> no key from the first burst. `key_down` rises exactly 7 edges after the second burst's first sample, with `grant_loc`=1.
3. Arbitration: `rem_req` (down) in the same cycle as the local `ev_down` -> `grant_loc`=1, `grant_rem`=0, `req_rej`=1 for one cycle.
4. Timeout: up request, sensors held 0 -> FAULT after 16 MOVE cycles, with `fault`=1 and keys 0. `fault_clr` -> IDLE.
5. Motor conflict: `ml`=`mr`=1 during MOVE -> FAULT on the next edge. A `rem_req` during FAULT -> `req_rej` only.
6. Reset mid-pulse: `rst_n`=0 while `key_up`=1 -> `key_up`=0 without waiting for an edge. After release: IDLE, counters 0.

Source files
------------

// File: rtl/door_cmd_sched.sv
// door_cmd_sched - command scheduler in front of the door FSM.
//
// Shares the door FSM's key_up/key_down inputs between a local push-button
// panel (synchronized + debounced) and a remote command port. Each motion is
// supervised with a travel timeout, and an opened door is reclosed
// automatically after a hold time.
//
// Ports:
//   clk2m                 2 MHz system clock, rising edge
//   rst_n                 asynchronous active-low reset
//   loc_up, loc_down      raw local buttons (asynchronous)
//   rem_req, rem_dir      remote request pulse / direction (1 = up)
//   sense_up, sense_down  raw limit switches (asynchronous)
//   ml, mr                door FSM motor outputs (monitor only)
//   fault_clr             pulse that leaves FAULT
//   key_up, key_down      key pulses to the door FSM
//   grant_loc, grant_rem  owner of the current motion
//   busy                  high while issuing/moving
//   fault                 high in FAULT
//   req_rej               one-cycle pulse per rejected request
module door_cmd_sched #(
  parameter int unsigned DEBOUNCE_CYC  = 20,
  parameter int unsigned PULSE_CYC     = 2,
  parameter int unsigned TRAVEL_TO_CYC = 4000,
  parameter int unsigned AUTOCLOSE_CYC = 20000
) (
  input  logic clk2m,
  input  logic rst_n,
  input  logic loc_up,
  input  logic loc_down,
  input  logic rem_req,
  input  logic rem_dir,
  input  logic sense_up,
  input  logic sense_down,
  input  logic ml,
  input  logic mr,
  input  logic fault_clr,
  output logic key_up,
  output logic key_down,
  output logic grant_loc,
  output logic grant_rem,
  output logic busy,
  output logic fault,
  output logic req_rej
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned PL_W = $clog2(PULSE_CYC + 1);
  localparam int unsigned TR_W = $clog2(TRAVEL_TO_CYC + 1);
  localparam int unsigned AC_W = $clog2(AUTOCLOSE_CYC + 1);

  localparam logic [DB_W-1:0] DB_MAX  = DB_W'(DEBOUNCE_CYC);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [PL_W-1:0] PL_MAX  = PL_W'(PULSE_CYC);
  localparam logic [PL_W-1:0] PL_LAST = PL_W'(PULSE_CYC - 1);
  localparam logic [TR_W-1:0] TR_MAX  = TR_W'(TRAVEL_TO_CYC);
  localparam logic [TR_W-1:0] TR_LAST = TR_W'(TRAVEL_TO_CYC - 1);
  localparam logic [AC_W-1:0] AC_MAX  = AC_W'(AUTOCLOSE_CYC);
  localparam logic [AC_W-1:0] AC_LAST = AC_W'(AUTOCLOSE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_MOVE,
    S_HOLD_OPEN,
    S_FAULT
  } state_t;

  // ---------------- input conditioning ----------------
  logic [1:0] loc_up_sync, loc_down_sync, sense_up_sync, sense_down_sync;

  always_ff @(posedge clk2m or negedge rst_n) begin
    if (!rst_n) begin
      loc_up_sync     <= '0;
      loc_down_sync   <= '0;
      sense_up_sync   <= '0;
      sense_down_sync <= '0;
    end else begin
      loc_up_sync     <= {loc_up_sync[0], loc_up};
      loc_down_sync   <= {loc_down_sync[0], loc_down};
      sense_up_sync   <= {sense_up_sync[0], sense_up};
      sense_down_sync <= {sense_down_sync[0], sense_down};
    end
  end

  logic       su_s, sd_s;
  logic [1:0] loc_s;      // [0] = up, [1] = down
  assign su_s  = sense_up_sync[1];
  assign sd_s  = sense_down_sync[1];
  assign loc_s = {loc_down_sync[1], loc_up_sync[1]};

  logic [DB_W-1:0] db_cnt [2];
  logic [1:0]      db_lvl, db_lvl_q, ev;

  // Level rises on the DEBOUNCE_CYC-th consecutive synced-high sample.
  always_ff @(posedge clk2m or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) db_cnt[i] <= '0;
      db_lvl   <= '0;
      db_lvl_q <= '0;
    end else begin
      db_lvl_q <= db_lvl;
      for (int unsigned i = 0; i < 2; i++) begin
        if (!loc_s[i]) begin
          db_cnt[i] <= '0;
          db_lvl[i] <= 1'b0;
        end else begin
          if (db_cnt[i] != DB_MAX) db_cnt[i] <= db_cnt[i] + DB_W'(1);
          if (db_cnt[i] >= DB_LAST) db_lvl[i] <= 1'b1;
        end
      end
    end
  end

  assign ev = db_lvl & ~db_lvl_q;

  // ---------------- arbitration ----------------
  logic req_valid, req_up, req_loc, req_rem, lost;

  always_comb begin
    req_valid = 1'b0;
    req_up    = 1'b0;
    req_loc   = 1'b0;
    req_rem   = 1'b0;
    lost      = 1'b0;
    if (ev[0] && ev[1]) begin
      lost = 1'b1;                      // conflicting local keys, remote loses too
    end else if (ev[0] || ev[1]) begin
      req_valid = 1'b1;
      req_up    = ev[0];
      req_loc   = 1'b1;
      lost      = rem_req;
    end else if (rem_req) begin
      req_valid = 1'b1;
      req_up    = rem_dir;
      req_rem   = 1'b1;
    end
  end

  // ---------------- FSM ----------------
  state_t          state, state_n;
  logic            dir_up, dir_up_n, own_loc, own_loc_n, own_rem, own_rem_n, rej;
  logic [PL_W-1:0] pulse_cnt;
  logic [TR_W-1:0] tr_cnt;
  logic [AC_W-1:0] ac_cnt;

  always_ff @(posedge clk2m or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      dir_up  <= 1'b0;
      own_loc <= 1'b0;
      own_rem <= 1'b0;
    end else begin
      state   <= state_n;
      dir_up  <= dir_up_n;
      own_loc <= own_loc_n;
      own_rem <= own_rem_n;
    end
  end

  always_comb begin
    state_n   = state;
    dir_up_n  = dir_up;
    own_loc_n = own_loc;
    own_rem_n = own_rem;
    rej       = lost;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (req_up ? su_s : sd_s) begin
            rej = 1'b1;
          end else begin
            state_n   = S_ISSUE;
            dir_up_n  = req_up;
            own_loc_n = req_loc;
            own_rem_n = req_rem;
          end
        end
      end
      S_ISSUE: begin
        if (req_valid) rej = 1'b1;
        if (pulse_cnt == PL_LAST) state_n = S_MOVE;
      end
      S_MOVE: begin
        if (req_valid) rej = 1'b1;
        // Target sensor wins over motor conflict and timeout.
        if (dir_up ? su_s : sd_s) begin
          state_n   = dir_up ? S_HOLD_OPEN : S_IDLE;
          own_loc_n = 1'b0;
          own_rem_n = 1'b0;
        end else if ((ml && mr) || (tr_cnt >= TR_LAST)) begin
          state_n   = S_FAULT;
          own_loc_n = 1'b0;
          own_rem_n = 1'b0;
        end
      end
      S_HOLD_OPEN: begin
        if (req_valid && !req_up && !sd_s) begin
          state_n   = S_ISSUE;
          dir_up_n  = 1'b0;
          own_loc_n = req_loc;
          own_rem_n = req_rem;
        end else begin
          if (req_valid) rej = 1'b1;
          if (!su_s) begin
            state_n = S_IDLE;
          end else if (ac_cnt >= AC_LAST) begin
            state_n   = S_ISSUE;       // auto-close: internal, unowned
            dir_up_n  = 1'b0;
            own_loc_n = 1'b0;
            own_rem_n = 1'b0;
          end
        end
      end
      S_FAULT: begin
        if (req_valid) rej = 1'b1;
        if (fault_clr) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Per-state counters: clear outside their state, saturate inside it.
  always_ff @(posedge clk2m or negedge rst_n) begin
    if (!rst_n) begin
      pulse_cnt <= '0;
      tr_cnt    <= '0;
      ac_cnt    <= '0;
    end else begin
      if (state != S_ISSUE)       pulse_cnt <= '0;
      else if (pulse_cnt != PL_MAX) pulse_cnt <= pulse_cnt + PL_W'(1);
      if (state != S_MOVE)        tr_cnt <= '0;
      else if (tr_cnt != TR_MAX)  tr_cnt <= tr_cnt + TR_W'(1);
      if (state != S_HOLD_OPEN)   ac_cnt <= '0;
      else if (ac_cnt != AC_MAX)  ac_cnt <= ac_cnt + AC_W'(1);
    end
  end

  // ---------------- registered outputs ----------------
  always_ff @(posedge clk2m or negedge rst_n) begin
    if (!rst_n) begin
      key_up    <= 1'b0;
      key_down  <= 1'b0;
      grant_loc <= 1'b0;
      grant_rem <= 1'b0;
      busy      <= 1'b0;
      fault     <= 1'b0;
      req_rej   <= 1'b0;
    end else begin
      key_up    <= (state == S_ISSUE) && dir_up;
      key_down  <= (state == S_ISSUE) && !dir_up;
      grant_loc <= ((state == S_ISSUE) || (state == S_MOVE)) && own_loc;
      grant_rem <= ((state == S_ISSUE) || (state == S_MOVE)) && own_rem;
      busy      <= (state == S_ISSUE) || (state == S_MOVE);
      fault     <= (state == S_FAULT);
      req_rej   <= rej;
    end
  end

endmodule

// File: tb/tb_door_cmd_sched.sv
// Testbench for door_cmd_sched: directed scenarios with randomized timing;
// expected waveforms are computed from edge-count arithmetic of the
// documented latencies.
module tb_door_cmd_sched;

  localparam int DB = 4;
  localparam int PW = 2;
  localparam int TO = 16;
  localparam int AC = 8;

  logic clk2m, rst_n, loc_up, loc_down, rem_req, rem_dir;
  logic sense_up, sense_down, ml, mr, fault_clr;
  logic key_up, key_down, grant_loc, grant_rem, busy, fault, req_rej;
  logic [6:0] all_out;

  assign all_out = {key_up, key_down, grant_loc, grant_rem, busy, fault, req_rej};

  door_cmd_sched #(
    .DEBOUNCE_CYC (DB),
    .PULSE_CYC    (PW),
    .TRAVEL_TO_CYC(TO),
    .AUTOCLOSE_CYC(AC)
  ) dut (
    .clk2m     (clk2m),
    .rst_n     (rst_n),
    .loc_up    (loc_up),
    .loc_down  (loc_down),
    .rem_req   (rem_req),
    .rem_dir   (rem_dir),
    .sense_up  (sense_up),
    .sense_down(sense_down),
    .ml        (ml),
    .mr        (mr),
    .fault_clr (fault_clr),
    .key_up    (key_up),
    .key_down  (key_down),
    .grant_loc (grant_loc),
    .grant_rem (grant_rem),
    .busy      (busy),
    .fault     (fault),
    .req_rej   (req_rej)
  );

  initial clk2m = 1'b0;
  always #5 clk2m = ~clk2m;

  int ecnt, nvec, nerr;
  int e, s, x, d, q, c, e0, g;

  // After tick(), ecnt is the index of the edge just taken; inputs driven now
  // are sampled at edge ecnt+1.
  task automatic tick();
    @(posedge clk2m);
    ecnt++;
    #1;
  endtask

  task automatic goto(input int t);
    while (ecnt < t) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, ecnt);
    end
  endtask

  initial begin
    ecnt = 0; nvec = 0; nerr = 0;
    rst_n = 1'b0; loc_up = 1'b0; loc_down = 1'b0; rem_req = 1'b0; rem_dir = 1'b0;
    sense_up = 1'b0; sense_down = 1'b0; ml = 1'b0; mr = 1'b0; fault_clr = 1'b0;

    // ---- reset state ----
    repeat (3) tick();
    chk("reset_outs", all_out, 0);
    #2 rst_n = 1'b1;

    // ---- 1: remote up, hold, auto-close, close ----
    sense_down = 1'b1;
    repeat (3) tick();
    chk("idle_outs", all_out, 0);
    repeat ($urandom_range(0, 5)) tick();
    rem_req = 1'b1; rem_dir = 1'b1;
    tick(); e = ecnt;
    rem_req = 1'b0; sense_down = 1'b0;
    s = e + PW + $urandom_range(1, 10);   // sense_up first sampled here
    x = s + 2 + AC;                       // auto-close ISSUE edge
    while (ecnt < x + PW + 1) begin
      if (ecnt == s - 1) sense_up = 1'b1;
      tick();
      chk("s1_key_up",    key_up,    (ecnt >= e + 1) && (ecnt <= e + PW));
      chk("s1_grant_rem", grant_rem, (ecnt >= e + 1) && (ecnt <= s + 2));
      chk("s1_busy",      busy,      ((ecnt >= e + 1) && (ecnt <= s + 2)) || (ecnt >= x + 1));
      chk("s1_key_down",  key_down,  (ecnt >= x + 1) && (ecnt <= x + PW));
      chk("s1_grant_loc", grant_loc, 0);
    end
    sense_up = 1'b0; sense_down = 1'b1;
    d = ecnt + 1;
    goto(d + 2);
    chk("s1_busy_close", busy, 1);
    tick();
    chk("s1_idle_outs", all_out, 0);

    // ---- 2: debounce rejects short burst, accepts long press ----
    sense_up = 1'b1; sense_down = 1'b0;
    repeat (4) tick();
    loc_down = 1'b1;
    repeat (3) tick();
    loc_down = 1'b0;
    g = $urandom_range(2, 5);
    for (int i = 0; i < g + DB + 2; i++) begin
      tick();
      chk("s2_burst_key", {key_down, key_up}, 0);
    end
    loc_down = 1'b1;
    tick(); e0 = ecnt;
    while (ecnt < e0 + DB + PW + 4) begin
      tick();
      chk("s2_key_down", key_down, (ecnt >= e0 + DB + 3) && (ecnt <= e0 + DB + 2 + PW));
      if (ecnt == e0 + DB + 3) chk("s2_grant_loc", {grant_loc, grant_rem}, 2'b10);
    end
    sense_down = 1'b1; sense_up = 1'b0; loc_down = 1'b0;
    repeat (5) tick();
    chk("s2_idle_outs", all_out, 0);

    // ---- 3: local event beats same-cycle remote request ----
    sense_up = 1'b1; sense_down = 1'b0;
    repeat (4) tick();
    loc_down = 1'b1;
    tick(); e0 = ecnt;
    goto(e0 + DB + 1);
    rem_req = 1'b1; rem_dir = 1'($urandom_range(0, 1));
    tick();
    rem_req = 1'b0;
    chk("s3_req_rej", req_rej, 1);
    chk("s3_key_early", key_down, 0);
    tick();
    chk("s3_req_rej_off", req_rej, 0);
    chk("s3_key_down", key_down, 1);
    chk("s3_grants", {grant_loc, grant_rem}, 2'b10);
    sense_down = 1'b1; sense_up = 1'b0; loc_down = 1'b0;
    repeat (6) tick();
    chk("s3_idle_outs", all_out, 0);

    // ---- 4: travel timeout, request rejected in MOVE, fault_clr ----
    repeat (2) tick();
    rem_req = 1'b1; rem_dir = 1'b1;
    tick(); e = ecnt;
    rem_req = 1'b0; sense_down = 1'b0;
    q = e + PW + $urandom_range(1, 10);
    while (ecnt < e + PW + TO + 2) begin
      rem_req = (ecnt == q - 1);
      rem_dir = 1'($urandom_range(0, 1));
      tick();
      chk("s4_req_rej", req_rej, ecnt == q);
      chk("s4_busy",    busy,    (ecnt >= e + 1) && (ecnt <= e + PW + TO));
      chk("s4_fault",   fault,   ecnt >= e + PW + TO + 1);
    end
    rem_req = 1'b0;
    chk("s4_fault_keys", {key_up, key_down, grant_loc, grant_rem}, 0);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    chk("s4_fault_hold", fault, 1);
    tick();
    chk("s4_fault_clr", all_out, 0);

    // ---- 5: end-stop reject, motor conflict, request in FAULT ----
    sense_down = 1'b1;
    repeat (3) tick();
    rem_req = 1'b1; rem_dir = 1'b0;
    tick();
    rem_req = 1'b0;
    chk("s5_endstop_rej", req_rej, 1);
    tick();
    chk("s5_endstop_nokey", {key_down, busy, req_rej}, 0);
    rem_req = 1'b1; rem_dir = 1'b1;
    tick(); e = ecnt;
    rem_req = 1'b0; sense_down = 1'b0;
    c = e + PW + $urandom_range(1, TO - 3);
    while (ecnt < c + 2) begin
      if (ecnt == c - 1) begin ml = 1'b1; mr = 1'b1; end
      tick();
      chk("s5_fault", fault, ecnt >= c + 1);
      chk("s5_busy",  busy,  (ecnt >= e + 1) && (ecnt <= c));
    end
    rem_req = 1'b1; rem_dir = 1'($urandom_range(0, 1));
    tick();
    rem_req = 1'b0;
    chk("s5_fault_rej", {fault, req_rej}, 2'b11);
    tick();
    chk("s5_fault_only", all_out, 7'b0000010);
    ml = 1'b0; mr = 1'b0; fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    tick();
    chk("s5_cleared", all_out, 0);

    // ---- 6: asynchronous reset mid-pulse ----
    sense_down = 1'b1;
    repeat (3) tick();
    rem_req = 1'b1; rem_dir = 1'b1;
    tick();
    rem_req = 1'b0;
    tick();
    chk("s6_key_before", key_up, 1);
    #2 rst_n = 1'b0;
    #1 chk("s6_key_async", key_up, 0);
    chk("s6_outs_async", all_out, 0);
    #2 rst_n = 1'b1;
    repeat (3) tick();
    chk("s6_idle_outs", all_out, 0);
    rem_req = 1'b1; rem_dir = 1'b1;
    tick(); e = ecnt;
    rem_req = 1'b0; sense_down = 1'b0;
    while (ecnt < e + PW + 2) begin
      tick();
      chk("s6_key_up", key_up, (ecnt >= e + 1) && (ecnt <= e + PW));
      chk("s6_busy",   busy,   1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
